// File: rtl/ex_iter_divider.sv
// Iterative restoring divider: signed/unsigned DIV/MOD, STEPS_PER_CYCLE quotient bits per cycle.
// done rises WIDTH/STEPS_PER_CYCLE+2 cycles after start is taken (1 cycle when b==0) and holds until ack or flush.
module ex_iter_divider #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic             is_signed,
  input  logic             op_rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q, op_rem_q;
  logic             neg_q_q, neg_r_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             b_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             last_iter;

  // Chained shift/subtract steps; the shifted partial remainder needs one extra bit.
  logic [WIDTH-1:0] r_v, q_v;
  logic [WIDTH:0]   r_sh, diff;

  assign accept    = start & ~flush & ((state == S_IDLE) | ((state == S_DONE) & ack));
  assign b_zero    = (b_q == '0);
  assign a_neg     = sgn_q & a_q[WIDTH-1];
  assign b_neg     = sgn_q & b_q[WIDTH-1];
  assign mag_a     = a_neg ? -a_q : a_q;
  assign mag_b     = b_neg ? -b_q : b_q;
  assign quo_fix   = neg_q_q ? -quo_q : quo_q;
  assign rem_fix   = neg_r_q ? -rem_q : rem_q;
  assign last_iter = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_PREP;
      S_PREP: begin
        busy      = 1'b1;
        state_nxt = b_zero ? S_DONE : S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (last_iter) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (ack) state_nxt = start ? S_PREP : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_comb begin
    r_v  = rem_q;
    q_v  = quo_q;
    r_sh = '0;
    diff = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      r_sh = {r_v, q_v[WIDTH-1]};
      q_v  = {q_v[WIDTH-2:0], 1'b0};
      diff = r_sh - {1'b0, div_q};
      if (!diff[WIDTH]) begin
        r_v    = diff[WIDTH-1:0];
        q_v[0] = 1'b1;
      end else begin
        r_v = r_sh[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      op_rem_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        a_q         <= a;
        b_q         <= b;
        sgn_q       <= is_signed;
        op_rem_q    <= op_rem;
        div_by_zero <= 1'b0;
      end
      case (state)
        S_PREP: begin
          cnt_q   <= '0;
          rem_q   <= '0;
          quo_q   <= mag_a;
          div_q   <= mag_b;
          neg_q_q <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          // Divide by zero skips iteration: remainder is the raw dividend.
          if (b_zero) begin
            div_by_zero <= 1'b1;
            result      <= op_rem_q ? a_q : '1;
          end
        end
        S_ITER: begin
          rem_q <= r_v;
          quo_q <= q_v;
          cnt_q <= cnt_q + 1'b1;
        end
        S_FIX:   result <= op_rem_q ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_iter_divider.sv
// Bench for ex_iter_divider at 1, 2 and 4 steps per cycle: scoreboard of expected results
// from an arithmetic reference model, with per-instance monitors popping on each done rise.
module tb_ex_iter_divider;

  typedef struct {
    int          d;
    logic [31:0] res;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [3];
  logic        flush_v [3];
  logic        ack_v   [3];
  logic        sgn_v   [3];
  logic        rem_v   [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  wire         busy_v  [3];
  wire         done_v  [3];
  wire         dbz_v   [3];
  wire  [31:0] res_v   [3];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic prev_done;

    ex_iter_divider #(.WIDTH(32), .STEPS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush_v[g]),
      .start      (start_v[g]),
      .is_signed  (sgn_v[g]),
      .op_rem     (rem_v[g]),
      .a          (a_v[g]),
      .b          (b_v[g]),
      .ack        (ack_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .result     (res_v[g]),
      .div_by_zero(dbz_v[g])
    );

    initial prev_done = 1'b0;

    always @(negedge clk) begin
      exp_t e;
      if (done_v[g] && !prev_done) begin
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_done_dut%0d", g), 64'(done_v[g]), 64'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("sb_dut_index_dut%0d", g), 64'(g), 64'(e.d));
          chk($sformatf("result_dut%0d", g), 64'(res_v[g]), 64'(e.res));
          chk($sformatf("div_by_zero_dut%0d", g), 64'(dbz_v[g]), 64'(e.dbz));
        end
      end
      prev_done = done_v[g];
    end
  end

  function automatic void ref_model(input logic s, input logic r, input logic [31:0] x,
                                    input logic [31:0] y, output logic [31:0] res,
                                    output logic dbz);
    longint sx, sy, q, m;
    if (y == 32'd0) begin
      dbz = 1'b1;
      res = r ? x : 32'hFFFF_FFFF;
      return;
    end
    dbz = 1'b0;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q   = sx / sy;
    m   = sx % sy;
    res = r ? m[31:0] : q[31:0];
  endfunction

  // Drives a new request at the current negedge; returns edges to done counting the sampling edge.
  task automatic issue(input logic [1:0] d, input bit push, input logic s, input logic r,
                       input logic [31:0] x, input logic [31:0] y, output int lat);
    exp_t        e;
    logic [31:0] rr;
    logic        z;
    ref_model(s, r, x, y, rr, z);
    if (push) begin
      e.d   = int'(d);
      e.res = rr;
      e.dbz = z;
      sb.push_back(e);
    end
    sgn_v[d]   = s;
    rem_v[d]   = r;
    a_v[d]     = x;
    b_v[d]     = y;
    start_v[d] = 1'b1;
    lat        = (y == 32'd0) ? 2 : 32 / (1 << d) + 3;
  endtask

  // Inputs are scrambled while the op runs to show they are ignored.
  task automatic wait_done(input logic [1:0] d, input int exp_l, input string nm);
    int edges;
    @(negedge clk);
    start_v[d] = 1'b0;
    ack_v[d]   = 1'b0;
    edges      = 1;
    chk({nm, "_done_low_after_start"}, 64'(done_v[d]), 64'd0);
    while (!done_v[d] && edges < 300) begin
      a_v[d]     = $urandom;
      b_v[d]     = $urandom;
      sgn_v[d]   = 1'($urandom);
      rem_v[d]   = 1'($urandom);
      start_v[d] = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    start_v[d] = 1'b0;
    chk({nm, "_latency"}, 64'(edges), 64'(exp_l));
  endtask

  task automatic ack_op(input logic [1:0] d);
    ack_v[d] = 1'b1;
    @(negedge clk);
    ack_v[d] = 1'b0;
    chk("done_low_after_ack", 64'(done_v[d]), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] d, input logic s, input logic r,
                        input logic [31:0] x, input logic [31:0] y, input string nm);
    int lat;
    issue(d, 1'b1, s, r, x, y, lat);
    wait_done(d, lat, nm);
    ack_op(d);
  endtask

  task automatic run_random(input logic [1:0] d, input int n_ops);
    int          lat;
    logic [31:0] x, y;
    bit          b2b;
    b2b = 1'b0;
    for (int i = 0; i < n_ops; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'd1;
        2:       y = 32'hFFFF_FFFF;
        3:       x = 32'h8000_0000;
        4:       y = 32'($urandom_range(1, 15));
        5:       y = y >> $urandom_range(4, 28);
        default: ;
      endcase
      ack_v[d] = b2b;
      issue(d, 1'b1, 1'($urandom), 1'($urandom), x, y, lat);
      wait_done(d, lat, "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
      b2b = ($urandom_range(0, 3) == 0) && (i < n_ops - 1);
      if (!b2b) ack_op(d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          edges;
    bit          saw;
    logic [31:0] held;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; flush_v[k] = 1'b0; ack_v[k] = 1'b0;
      sgn_v[k]   = 1'b0; rem_v[k]   = 1'b0;
      a_v[k]     = '0;   b_v[k]     = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", 64'(busy_v[k]), 64'd0);
      chk("reset_done", 64'(done_v[k]), 64'd0);
      chk("reset_result", 64'(res_v[k]), 64'd0);
      chk("reset_dbz", 64'(dbz_v[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'd0, 1'b0, 1'b0, 32'd100, 32'd7, "u100_7_quo");
    run_op(2'd0, 1'b0, 1'b1, 32'd100, 32'd7, "u100_7_rem");
    run_op(2'd0, 1'b1, 1'b0, -32'sd7, 32'd2, "s-7_2_quo");
    run_op(2'd0, 1'b1, 1'b1, -32'sd7, 32'd2, "s-7_2_rem");
    run_op(2'd0, 1'b1, 1'b0, 32'd7, -32'sd2, "s7_-2_quo");
    run_op(2'd0, 1'b1, 1'b1, 32'd7, -32'sd2, "s7_-2_rem");
    run_op(2'd0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "smin_-1_quo");
    run_op(2'd0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "smin_-1_rem");
    run_op(2'd0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "umin_-1_quo");
    run_op(2'd0, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "umin_-1_rem");
    run_op(2'd0, 1'b0, 1'b0, 32'd5, 32'd0, "div0_quo");

    // Divide-by-zero remainder, held unacknowledged to see the result stay put.
    issue(2'd0, 1'b1, 1'b1, 1'b1, 32'd5, 32'd0, lat);
    wait_done(2'd0, lat, "div0_rem");
    repeat (3) @(negedge clk);
    chk("div0_hold_done", 64'(done_v[0]), 64'd1);
    chk("div0_hold_result", 64'(res_v[0]), 64'd5);
    chk("div0_hold_dbz", 64'(dbz_v[0]), 64'd1);
    ack_op(2'd0);
    run_op(2'd0, 1'b0, 1'b0, 32'd9, 32'd3, "after_div0");

    // Flush mid-operation: the tenth edge samples flush.
    held = res_v[0];
    issue(2'd0, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3, lat);
    @(negedge clk);
    start_v[0] = 1'b0;
    edges = 1;
    while (edges < 9) begin
      @(negedge clk);
      edges++;
    end
    flush_v[0] = 1'b1;
    @(negedge clk);
    flush_v[0] = 1'b0;
    chk("flush_busy", 64'(busy_v[0]), 64'd0);
    chk("flush_done", 64'(done_v[0]), 64'd0);
    chk("flush_result_kept", 64'(res_v[0]), 64'(held));
    issue(2'd0, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd3, lat);
    wait_done(2'd0, lat, "after_flush");
    ack_op(2'd0);

    // Flush and start together in IDLE: start is dropped.
    issue(2'd0, 1'b0, 1'b0, 1'b0, 32'd50, 32'd5, lat);
    flush_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    flush_v[0] = 1'b0;
    chk("flush_start_busy", 64'(busy_v[0]), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_v[0]) saw = 1'b1;
    end
    chk("flush_start_no_done", 64'(saw), 64'd0);

    // Flush while DONE clears done and div_by_zero but keeps result.
    issue(2'd0, 1'b1, 1'b0, 1'b1, 32'd77, 32'd0, lat);
    wait_done(2'd0, lat, "div0_then_flush");
    flush_v[0] = 1'b1;
    @(negedge clk);
    flush_v[0] = 1'b0;
    chk("flush_done_cleared", 64'(done_v[0]), 64'd0);
    chk("flush_dbz_cleared", 64'(dbz_v[0]), 64'd0);
    chk("flush_done_result_kept", 64'(res_v[0]), 64'd77);

    // Four steps per cycle, back-to-back via ack&start.
    issue(2'd2, 1'b1, 1'b1, 1'b0, -32'sd100, 32'd7, lat);
    wait_done(2'd2, lat, "s4_first");
    ack_v[2] = 1'b1;
    issue(2'd2, 1'b1, 1'b0, 1'b1, 32'd12345, 32'd100, lat);
    wait_done(2'd2, lat, "s4_b2b");
    ack_op(2'd2);
    run_op(2'd2, 1'b0, 1'b0, 32'd5, 32'd0, "s4_div0");

    for (int k = 0; k < 3; k++) run_random(2'(k), 40);

    // Reset in the middle of an operation.
    issue(2'd2, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3, lat);
    @(negedge clk);
    start_v[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy_v[2]), 64'd0);
    chk("midreset_done", 64'(done_v[2]), 64'd0);
    chk("midreset_result", 64'(res_v[2]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[2]) saw = 1'b1;
    end
    chk("midreset_no_done", 64'(saw), 64'd0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
